i2c_transfer_sequencer: RTL

Command-level front end for the ToF I2C bit engine (`I2C_Entity`), sitting directly upstream of it. It accepts one register-access command at a time and generates the engine's single-cycle `start` pulses. Register reads are issued as the engine's two-transaction sequence. It streams write bytes into `data_in`, decrements `nb_of_bytes` as bytes complete, captures read bytes from `data_out`, and reports completion and errors to the sensor control FSM.

---
 rtl/i2c_transfer_sequencer_if.sv | 42 ++++
 rtl/i2c_transfer_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/i2c_transfer_sequencer_if.sv
// Command, byte-stream and engine-side signals of the I2C transfer sequencer.
// slave = sequencer view; master = sensor control FSM plus bit engine view.
interface i2c_transfer_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_is_read;
    logic [6:0]  cmd_slave_address;
    logic [15:0] cmd_register_address;
    logic [16:0] cmd_nb_of_bytes;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        done;
    logic [1:0]  error;
    logic        ent_start;
    logic        ent_is_read;
    logic        ent_reset;
    logic [6:0]  ent_slave_address;
    logic [15:0] ent_register_address;
    logic [16:0] ent_nb_of_bytes;
    logic [7:0]  ent_data_in;
    logic        ent_ready;
    logic [7:0]  ent_data_out;

    modport slave (
        input  cmd_valid, cmd_is_read, cmd_slave_address, cmd_register_address, cmd_nb_of_bytes,
        input  wr_data, wr_valid, ent_ready, ent_data_out,
        output cmd_ready, wr_ready, rd_data, rd_valid, done, error,
        output ent_start, ent_is_read, ent_reset, ent_slave_address, ent_register_address,
        output ent_nb_of_bytes, ent_data_in
    );

    modport master (
        output cmd_valid, cmd_is_read, cmd_slave_address, cmd_register_address, cmd_nb_of_bytes,
        output wr_data, wr_valid, ent_ready, ent_data_out,
        input  cmd_ready, wr_ready, rd_data, rd_valid, done, error,
        input  ent_start, ent_is_read, ent_reset, ent_slave_address, ent_register_address,
        input  ent_nb_of_bytes, ent_data_in
    );
endinterface

// File: rtl/i2c_transfer_sequencer.sv
// Command-level front end for the I2C bit engine: start pulses, write streaming, read capture.
// Define I2C_SEQ_WATCHDOG_EN to abort stalled XFER/DRAIN phases after WDT_CYCLES.
module i2c_transfer_sequencer #(
    parameter int ADDR_PHASE_CYCLES = 36,
    parameter int WDT_CYCLES        = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    i2c_transfer_sequencer_if.slave bus
);
`ifdef I2C_SEQ_WATCHDOG_EN
    localparam bit WDT_EN = 1'b1;
`else
    localparam bit WDT_EN = 1'b0;
`endif
    localparam int CNT_MAX = (ADDR_PHASE_CYCLES > WDT_CYCLES) ? ADDR_PHASE_CYCLES : WDT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {IDLE, FETCH, ADDR, AWAIT, XSTART, XFER, DRAIN, ABORT, DONE} state_t;
    state_t state, next_state;

    logic             run_q, ready_d, bc, fall, accept, nb_zero, wdt_expire;
    logic [CNT_W-1:0] cnt;
    logic             is_read_q, rd_valid_q;
    logic [6:0]       sa_q;
    logic [15:0]      ra_q;
    logic [16:0]      nb_q;
    logic [7:0]       data_in_q, rd_data_q;
    logic [1:0]       error_q;
    logic             cmd_ready_c, wr_ready_c, start_c, done_c, ent_reset_c;

    // The engine holds ready as a level; only its edges mark byte completion / return to idle.
    assign bc         = bus.ent_ready & ~ready_d;
    assign fall       = ~bus.ent_ready & ready_d;
    assign nb_zero    = (nb_q == '0);
    assign accept     = bus.cmd_valid & cmd_ready_c;
    assign wdt_expire = WDT_EN && (cnt == CNT_W'(WDT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = bus.cmd_is_read ? ADDR : FETCH;
            FETCH:   if (bus.wr_valid) next_state = XSTART;
            ADDR:    next_state = AWAIT;
            AWAIT:   if (cnt == CNT_W'(ADDR_PHASE_CYCLES - 1)) next_state = XSTART;
            XSTART:  next_state = XFER;
            XFER:    if (bc && nb_zero) next_state = DRAIN;
                     else if (!bc && wdt_expire) next_state = ABORT;
            DRAIN:   if (fall) next_state = DONE;
                     else if (wdt_expire) next_state = ABORT;
            ABORT:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_c = 1'b0;
        wr_ready_c  = 1'b0;
        start_c     = 1'b0;
        done_c      = 1'b0;
        ent_reset_c = 1'b0;
        case (state)
            IDLE:         cmd_ready_c = run_q;
            FETCH:        wr_ready_c  = 1'b1;
            ADDR, XSTART: start_c     = 1'b1;
            XFER:         wr_ready_c  = bc & ~is_read_q & ~nb_zero;
            ABORT:        ent_reset_c = WDT_EN;
            DONE:         done_c      = 1'b1;
            default:      ;
        endcase
    end

    // Shared counter: address-phase gap in AWAIT, stall watchdog in XFER/DRAIN.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            ready_d <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            ready_d <= bus.ent_ready;
            run_q   <= 1'b1;
            if (state != next_state || bc) cnt <= '0;
            else                           cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            is_read_q  <= 1'b0;
            sa_q       <= '0;
            ra_q       <= '0;
            nb_q       <= '0;
            data_in_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            error_q    <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            if (accept) begin
                is_read_q <= bus.cmd_is_read;
                sa_q      <= bus.cmd_slave_address;
                ra_q      <= bus.cmd_register_address;
                nb_q      <= bus.cmd_nb_of_bytes;
                error_q   <= '0;
            end
            if (state == FETCH && bus.wr_valid) data_in_q <= bus.wr_data;
            // ent_data_in must change in the ack cycle itself; the engine shifts it 2 cycles later.
            if (state == XFER && bc) begin
                if (!nb_zero) begin
                    nb_q <= nb_q - 17'd1;
                    if (!is_read_q) begin
                        if (bus.wr_valid) data_in_q <= bus.wr_data;
                        else begin
                            data_in_q  <= 8'hFF;
                            error_q[0] <= 1'b1;
                        end
                    end
                end
                if (is_read_q) begin
                    rd_data_q  <= bus.ent_data_out;
                    rd_valid_q <= 1'b1;
                end
            end
            if (state == ABORT && WDT_EN) error_q[1] <= 1'b1;
        end
    end

    assign bus.cmd_ready            = cmd_ready_c;
    assign bus.wr_ready             = wr_ready_c;
    assign bus.rd_data              = rd_data_q;
    assign bus.rd_valid             = rd_valid_q;
    assign bus.done                 = done_c;
    assign bus.error                = error_q;
    assign bus.ent_start            = start_c;
    assign bus.ent_is_read          = is_read_q;
    assign bus.ent_reset            = ent_reset_c;
    assign bus.ent_slave_address    = sa_q;
    assign bus.ent_register_address = ra_q;
    assign bus.ent_nb_of_bytes      = nb_q;
    assign bus.ent_data_in          = data_in_q;
endmodule
